// File: rtl/f_pc_unit_pkg.sv
// Shared constants, state encoding and address-check helper for the fetch-stage PC unit.
package f_pc_unit_pkg;

  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] TRAPPED_ADDRESS = 32'h0000_4180;
  localparam logic [31:0] IM_LO           = 32'h0000_3000;
  localparam logic [31:0] IM_HI           = 32'h0000_6FFF;
  localparam logic [31:0] CNT_MAX         = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FPC_BOOT  = 2'd0,
    FPC_RUN   = 2'd1,
    FPC_STALL = 2'd2
  } fpc_state_t;

  // A fetch address raises AdEL when misaligned or outside instruction memory.
  function automatic logic fetch_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/f_pc_unit_if.sv
// Bundle between the next-PC/hazard/CP0 side (master) and the fetch PC unit (slave).
interface f_pc_unit_if;

  logic [31:0] NPC;
  logic        stall;
  logic        IntReq;
  logic        D_eret;
  logic [31:0] EPC;
  logic [31:0] F_PC;
  logic        F_valid;
  logic        F_exc_adel;
  logic        F_flush;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output NPC, stall, IntReq, D_eret, EPC,
    input  F_PC, F_valid, F_exc_adel, F_flush, fetch_cnt, stall_cnt
  );

  modport slave (
    input  NPC, stall, IntReq, D_eret, EPC,
    output F_PC, F_valid, F_exc_adel, F_flush, fetch_cnt, stall_cnt
  );

endinterface

// File: rtl/f_pc_unit_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt32
  import f_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  // Count enabled events, holding once the maximum is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 32'h0000_0000;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 32'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC register: latches NPC, holds on stall, redirects on interrupt or eret,
// tags the fetch with valid/AdEL, flushes the post-eret fetch and counts fetch/stall cycles.
module f_pc_unit
  import f_pc_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  f_pc_unit_if.slave   bus
);

  fpc_state_t  r_state;
  logic [31:0] r_pc;
  logic        r_valid;

  logic        w_active;
  logic        w_advance;
  logic        w_stall_hit;
  logic [31:0] w_fetch_cnt;
  logic [31:0] w_stall_cnt;

  // Advancing (eret or plain NPC) and holding both require no pending IntReq.
  assign w_active    = (r_state == FPC_RUN) || (r_state == FPC_STALL);
  assign w_advance   = w_active & ~bus.IntReq & ~bus.stall;
  assign w_stall_hit = w_active & ~bus.IntReq &  bus.stall;

  // PC select and state sequencing; RUN and STALL share the same priority order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FPC_BOOT;
      r_pc    <= INITIAL_ADDRESS;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FPC_BOOT: begin
          r_state <= FPC_RUN;
          r_pc    <= r_pc;
          r_valid <= 1'b1;
        end
        FPC_RUN, FPC_STALL: begin
          r_valid <= 1'b1;
          if (bus.IntReq) begin
            r_state <= FPC_RUN;
            r_pc    <= TRAPPED_ADDRESS;
          end else if (bus.D_eret && !bus.stall) begin
            r_state <= FPC_RUN;
            r_pc    <= bus.EPC;
          end else if (bus.stall) begin
            r_state <= FPC_STALL;
            r_pc    <= r_pc;
          end else begin
            r_state <= FPC_RUN;
            r_pc    <= bus.NPC;
          end
        end
        default: begin
          r_state <= FPC_BOOT;
          r_pc    <= INITIAL_ADDRESS;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt32 u_fetch_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .i_inc (w_advance),
    .o_cnt (w_fetch_cnt)
  );

  sat_cnt32 u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .i_inc (w_stall_hit),
    .o_cnt (w_stall_cnt)
  );

  // Interrupt-driven flushes belong to CP0/hazard logic, so IntReq suppresses ours.
  assign bus.F_PC       = r_pc;
  assign bus.F_valid    = r_valid;
  assign bus.F_exc_adel = fetch_adel(r_pc);
  assign bus.F_flush    = r_valid & bus.D_eret & ~bus.stall & ~bus.IntReq;
  assign bus.fetch_cnt  = w_fetch_cnt;
  assign bus.stall_cnt  = w_stall_cnt;

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch PC.
module tb_f_pc_unit;
  import f_pc_unit_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  f_pc_unit_if bus ();

  f_pc_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic [31:0] m_sc;
  logic        m_booted;

  function automatic logic ref_adel(input logic [31:0] pc);
    return (pc % 32'd4 != 32'd0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
  endfunction

  function automatic logic ref_flush();
    return m_booted && bus.D_eret && !bus.stall && !bus.IntReq;
  endfunction

  task automatic model_reset();
    m_pc     = 32'h0000_3000;
    m_fc     = 32'd0;
    m_sc     = 32'd0;
    m_booted = 1'b0;
  endtask

  task automatic drive(input logic [31:0] npc, input logic st, input logic ir,
                       input logic er, input logic [31:0] epc);
    bus.NPC    = npc;
    bus.stall  = st;
    bus.IntReq = ir;
    bus.D_eret = er;
    bus.EPC    = epc;
    #1;
  endtask

  // One clock edge of the reference model, then park at the following negedge.
  task automatic advance();
    @(posedge clk);
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (bus.IntReq) begin
      m_pc = 32'h0000_4180;
    end else if (bus.D_eret && !bus.stall) begin
      m_pc = bus.EPC;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end else if (bus.stall) begin
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    end else begin
      m_pc = bus.NPC;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #20;
    model_reset();
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL reset_pc: got %h want %h", bus.F_PC, m_pc); end
    vectors++; if (bus.F_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.F_valid); end
    vectors++; if (bus.F_exc_adel !== 1'b0) begin miscompares++; $display("FAIL reset_adel: got %b want 0", bus.F_exc_adel); end
    vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL reset_fetch_cnt: got %0d want %0d", bus.fetch_cnt, m_fc); end
    vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d want %0d", bus.stall_cnt, m_sc); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_boot_seq();
    for (int i = 0; i < 5; i++) begin
      drive(m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL boot_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.F_valid !== m_booted) begin miscompares++; $display("FAIL boot_valid[%0d]: got %b want %b", i, bus.F_valid, m_booted); end
      vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL boot_fetch_cnt[%0d]: got %0d want %0d", i, bus.fetch_cnt, m_fc); end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3014, 1'b1, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt, m_sc); end
      advance();
    end
    drive(32'h0000_3014, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL stall_hold_pc: got %h want %h", bus.F_PC, m_pc); end
    vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL stall_total: got %0d want %0d", bus.stall_cnt, m_sc); end
    vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL stall_fetch_cnt: got %0d want %0d", bus.fetch_cnt, m_fc); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL stall_resume_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      advance();
    end
  endtask

  task automatic test_intreq_stall();
    drive(m_pc + 32'd4, 1'b1, 1'b1, 1'b0, 32'h0);
    vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL irq_flush: got %b want %b", bus.F_flush, ref_flush()); end
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL irq_pre_pc: got %h want %h", bus.F_PC, m_pc); end
    advance();
    drive(m_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL irq_pc: got %h want %h", bus.F_PC, m_pc); end
    vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL irq_fetch_cnt: got %0d want %0d", bus.fetch_cnt, m_fc); end
    vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL irq_stall_cnt: got %0d want %0d", bus.stall_cnt, m_sc); end
  endtask

  task automatic test_eret();
    drive(m_pc + 32'd4, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
    vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL eret_flush: got %b want %b", bus.F_flush, ref_flush()); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(m_pc + 32'd4, 1'b1, 1'b0, 1'b1, 32'h0000_3080);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL eret_stall_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL eret_stall_flush[%0d]: got %b want %b", i, bus.F_flush, ref_flush()); end
      advance();
    end
    drive(m_pc + 32'd4, 1'b0, 1'b0, 1'b1, 32'h0000_3080);
    vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL eret_retry_flush: got %b want %b", bus.F_flush, ref_flush()); end
    advance();
    drive(m_pc + 32'd4, 1'b1, 1'b1, 1'b1, 32'h0000_3000);
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL eret_retry_pc: got %h want %h", bus.F_PC, m_pc); end
    vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL eret_irq_flush: got %b want %b", bus.F_flush, ref_flush()); end
    advance();
  endtask

  task automatic test_adel();
    logic [31:0] seq [5];
    seq = '{32'h0000_3002, 32'h0000_2FFC, 32'h0000_7000, 32'h0000_6FFC, 32'hFFFF_FFFC};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b0, 32'h0);
      advance();
      drive(32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'h0);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL adel_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.F_exc_adel !== ref_adel(m_pc)) begin miscompares++; $display("FAIL adel_flag[%0d]: got %b want %b", i, bus.F_exc_adel, ref_adel(m_pc)); end
      drive(seq[i], 1'b1, 1'b0, 1'b0, 32'h0);
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] npc;
    logic [31:0] epc;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       npc = $urandom;
        1:       npc = 32'h0000_3001 + ($urandom_range(0, 4095) * 32'd4);
        default: npc = 32'h0000_3000 + ($urandom_range(0, 4095) * 32'd4);
      endcase
      epc = 32'h0000_3000 + ($urandom_range(0, 4095) * 32'd4);
      drive(npc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0), epc);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.F_valid !== m_booted) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.F_valid, m_booted); end
      vectors++; if (bus.F_exc_adel !== ref_adel(m_pc)) begin miscompares++; $display("FAIL rnd_adel[%0d]: got %b want %b", i, bus.F_exc_adel, ref_adel(m_pc)); end
      vectors++; if (bus.F_flush !== ref_flush()) begin miscompares++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, bus.F_flush, ref_flush()); end
      vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL rnd_fetch_cnt[%0d]: got %0d want %0d", i, bus.fetch_cnt, m_fc); end
      vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt, m_sc); end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL mid_reset_pc: got %h want %h", bus.F_PC, m_pc); end
    vectors++; if (bus.F_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", bus.F_valid); end
    vectors++; if (bus.fetch_cnt !== m_fc) begin miscompares++; $display("FAIL mid_reset_fetch_cnt: got %0d want %0d", bus.fetch_cnt, m_fc); end
    vectors++; if (bus.stall_cnt !== m_sc) begin miscompares++; $display("FAIL mid_reset_stall_cnt: got %0d want %0d", bus.stall_cnt, m_sc); end
    vectors++; if (bus.F_flush !== 1'b0) begin miscompares++; $display("FAIL mid_reset_flush: got %b want 0", bus.F_flush); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(m_pc + 32'd4, (i == 0), (i == 0), 1'b0, 32'h0);
      vectors++; if (bus.F_PC !== m_pc) begin miscompares++; $display("FAIL reboot_pc[%0d]: got %h want %h", i, bus.F_PC, m_pc); end
      vectors++; if (bus.F_valid !== m_booted) begin miscompares++; $display("FAIL reboot_valid[%0d]: got %b want %b", i, bus.F_valid, m_booted); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_stall();
    test_intreq_stall();
    test_eret();
    test_adel();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
Name: f_pc_unit

Overview:
- Fetch-stage PC register. It is the consumer of the next-PC value that the F/D next-PC logic produces.
- Each cycle it latches NPC, or holds under stall, or redirects to the handler or EPC on interrupt/eret.
- It tags the fetched PC with an AdEL fetch exception and a valid bit.
- It drives the flush for the wrongly-fetched post-eret instruction and keeps fetch/stall performance counters. It sits between the next-PC logic and IM / the F/D pipeline register.

Parameters:
- INITIAL_ADDRESS, 32'h0000_3000, PC value at reset.
- TRAPPED_ADDRESS, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IM_HI, 32'h0000_6FFF, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- NPC  in  32  next PC from the next-PC logic (already handles branch/jump/jr).
- stall  in  1  hazard-unit stall: hold the PC.
- IntReq  in  1  CP0 interrupt/exception request; overrides stall.
- D_eret  in  1  eret currently in D.
- EPC  in  32  CP0 EPC value (forwarded).
- F_PC  out  32  current fetch address to IM and the F/D register.
- F_valid  out  1  F_PC holds a real fetch (0 during BOOT).
- F_exc_adel  out  1  F_PC misaligned or outside [IM_LO, IM_HI].
- F_flush  out  1  F/D register must load a bubble this edge.
- fetch_cnt  out  32  count of advancing fetch cycles.
- stall_cnt  out  32  count of stalled cycles.

Behaviour:
- Reset (async, reset_n=0): F_PC=INITIAL_ADDRESS, state=BOOT, F_valid=0, F_exc_adel=0, fetch_cnt=0, stall_cnt=0.
- Reset assert mid-operation clears all of the above immediately, without waiting for a clock edge.
- States:
  - BOOT: F_valid=0, F_PC held. Next edge goes to RUN unconditionally; stall and IntReq are ignored in BOOT.
  - RUN: F_valid=1. Next-PC select, first match wins:
    1. IntReq=1: next=TRAPPED_ADDRESS.
    2. D_eret=1 and stall=0: next=EPC.
    3. stall=1: next=F_PC, go to STALL.
    4. otherwise: next=NPC.
  - STALL: same select as RUN. Return to RUN on the first edge where stall=0 or IntReq=1.
- F_exc_adel is combinational from F_PC:
  - 1 if F_PC[1:0]!=0, or F_PC<IM_LO, or F_PC>IM_HI (unsigned compares).
  - Holds steady while stalled. On an AdEL fetch, IM is still addressed; downstream replaces the instruction with nop.
- F_flush is combinational: F_flush = F_valid & D_eret & ~stall & ~IntReq.
  - IntReq flushes are owned by the hazard/CP0 logic, not here.
- fetch_cnt: +1 on each edge in RUN/STALL where the PC advances (rule 2 or 4). Saturates at 32'hFFFF_FFFF.
- stall_cnt: +1 on each edge where rule 3 applies. Saturates at 32'hFFFF_FFFF.
- A redirect (rule 1) increments neither counter.
- Latency: NPC → F_PC is one cycle. No combinational path from NPC to F_PC.
- Simultaneous events:
  - IntReq+stall: redirect wins.
  - IntReq+D_eret: IntReq wins, F_flush=0.
  - D_eret+stall: hold, no flush; eret is retried next cycle.
- NPC/EPC wrap above 32'hFFFF_FFFC: value latched as-is, flagged by AdEL.

Decomposition:
- Shared constants header (existing constants include): INITIAL_ADDRESS, TRAPPED_ADDRESS, IM bounds, and the 2-bit state encodings FPC_BOOT=0, FPC_RUN=1, FPC_STALL=2.
- One natural sub-module: sat_cnt32, a saturating 32-bit counter with an inc enable and async active-low clear. It is instantiated twice.

Test Plan:
- Reset release, NPC=F_PC+4 each cycle:
  - F_PC=0x3000 with F_valid=0 for one cycle.
  - Then F_PC 0x3000, 0x3004, 0x3008…; fetch_cnt=2 after two advances.
- stall=1 for 3 cycles at F_PC=0x3010, NPC=0x3014:
  - F_PC held at 0x3010; stall_cnt=3; fetch_cnt unchanged.
  - Next edge after stall drops gives F_PC=0x3014.
- IntReq=1 with stall=1 at F_PC=0x3020 → next F_PC=0x4180; F_flush=0; counters unchanged.
- D_eret=1, EPC=0x3040, stall=0 → F_flush=1 this cycle; next F_PC=0x3040.
- Same with stall=1 → F_flush=0; F_PC held until stall drops.
- NPC sequence 0x3002, 0x2FFC, 0x7000, 0x6FFC → F_exc_adel=1, 1, 1, 0 respectively.
- reset_n pulsed low between edges mid-run → F_PC=0x3000, counters=0, F_valid=0 without a clock edge; BOOT repeats.
